// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX path: state encoding of the frame
// serialiser and the default frame geometry.
package uart_pkg;

   // Frame serialiser states. PARITY is only reachable when the design is
   // built with UART_TX_PARITY_EN; otherwise it is an illegal encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } state_t;

   localparam int DATA_BITS_DEF = 8;
   localparam int STOP_BITS_DEF = 1;

endpackage

// File: rtl/uart_tx_frame.sv
// Byte serialiser for the UART TX path. Accepts a byte over valid/ready and
// shifts out one frame on tx, LSB first, with bit boundaries paced by the
// one-cycle baud_tick from the upstream divider.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (8E1);
// left undefined the frame is plain 8N1.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int STOP_BITS = STOP_BITS_DEF,
   parameter int CNT_W     = 3
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   state_t               state_q,    state_nxt;
   logic [DATA_BITS-1:0] shift_q,    shift_nxt;
   logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_nxt;
   logic                 stop_cnt_q, stop_cnt_nxt;
   logic                 tx_q,       tx_nxt;
   logic                 ready_q,    ready_nxt;
   logic                 busy_q,     busy_nxt;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q,   parity_nxt;
`endif

   // State and datapath registers; reset forces the line idle-high at once.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_nxt;
         shift_q    <= shift_nxt;
         bit_cnt_q  <= bit_cnt_nxt;
         stop_cnt_q <= stop_cnt_nxt;
         tx_q       <= tx_nxt;
         ready_q    <= ready_nxt;
         busy_q     <= busy_nxt;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_nxt;
`endif
      end
   end

   // Next-state and next-datapath logic; only accept ignores baud_tick.
   always_comb begin
      // NOTE: every signal gets a hold-value default before the case so no
      // path leaves one unassigned, which would infer a latch.
      state_nxt    = state_q;
      shift_nxt    = shift_q;
      bit_cnt_nxt  = bit_cnt_q;
      stop_cnt_nxt = stop_cnt_q;
      tx_nxt       = tx_q;
      ready_nxt    = ready_q;
      busy_nxt     = busy_q;
`ifdef UART_TX_PARITY_EN
      parity_nxt   = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (tx_valid && ready_q) begin
               shift_nxt = tx_data;
               ready_nxt = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         // A tick in the accept cycle is seen in IDLE and dropped, so the
         // start bit always begins on a later tick.
         ST_WAIT: begin
            if (baud_tick) begin
               tx_nxt    = 1'b0;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               tx_nxt      = shift_q[0];
               shift_nxt   = shift_q >> 1;
               bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
               parity_nxt  = shift_q[0];
`endif
               state_nxt   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q != BIT_LAST) begin
                  tx_nxt      = shift_q[0];
                  shift_nxt   = shift_q >> 1;
                  bit_cnt_nxt = bit_cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                  parity_nxt  = parity_q ^ shift_q[0];
`endif
               end else begin
`ifdef UART_TX_PARITY_EN
                  // The parity register already covers the last data bit,
                  // so it goes on the line for the whole PARITY period.
                  tx_nxt    = parity_q;
                  state_nxt = ST_PARITY;
`else
                  tx_nxt       = 1'b1;
                  stop_cnt_nxt = 1'b0;
                  state_nxt    = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick) begin
               tx_nxt       = 1'b1;
               stop_cnt_nxt = 1'b0;
               state_nxt    = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (baud_tick) begin
               if (stop_cnt_q != STOP_LAST) begin
                  stop_cnt_nxt = stop_cnt_q + 1'b1;
               end else begin
                  ready_nxt = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         // Illegal encodings (including PARITY when not built in) recover
         // to an idle line.
         default: begin
            state_nxt    = ST_IDLE;
            tx_nxt       = 1'b1;
            ready_nxt    = 1'b1;
            busy_nxt     = 1'b0;
            bit_cnt_nxt  = '0;
            stop_cnt_nxt = 1'b0;
         end
      endcase
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a table of bytes plus hand-written
// corner sequences; a line receiver compares frames against a scoreboard.
// Honours UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_tx_frame;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_TICKS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;

   uart_tx_frame #(
      .DATA_BITS(DATA_BITS),
      .STOP_BITS(STOP_BITS),
      .CNT_W    (3)
   ) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .baud_tick(baud_tick),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] data;
      int         period;
      logic       exp_par;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   period = 8;
   int   tick_cnt = 0;
   bit   auto_tick = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk_in);
      #1;
      if (auto_tick) begin
         tick_cnt  = (tick_cnt >= period - 1) ? 0 : tick_cnt + 1;
         baud_tick = (tick_cnt == period - 1);
      end
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      for (int i = 0; i < 20000 && seen < n; i++) begin
         if (baud_tick) seen++;
         step();
      end
      check("wait_ticks_budget", seen, n);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (tx_ready && !busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check("idle_timeout", ok, 1);
   endtask

   task automatic send(input logic [7:0] d, input logic p);
      for (int i = 0; i < 20000 && !tx_ready; i++) step();
      tx_valid = 1'b1;
      tx_data  = d;
      exp_q.push_back('{d, p});
      step();
      tx_valid = 1'b0;
   endtask

   // Line receiver: samples tx in each tick cycle, i.e. the bit that began
   // at the previous tick, and checks complete frames against the queue.
   int         rx_state = 0;
   int         rx_cnt = 0;
   logic [7:0] rx_bits = '0;
   logic       rx_par = 1'b0;
   exp_t       rx_exp;

   always @(negedge clk_in) begin
      if (!rst_n) begin
         rx_state = 0;
      end else if (baud_tick) begin
         case (rx_state)
            0: if (tx == 1'b0) begin
                  rx_state = 1;
                  rx_cnt   = 0;
               end
            1: begin
                  rx_bits[rx_cnt] = tx;
                  rx_cnt++;
                  if (rx_cnt == DATA_BITS) rx_state = (PAR_BITS != 0) ? 2 : 3;
               end
            2: begin
                  rx_par   = tx;
                  rx_state = 3;
               end
            default: begin
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL frame_unexpected: got data %02h, expected no frame", rx_bits);
                  end else begin
                     rx_exp = exp_q.pop_front();
                     check("frame_data", rx_bits, rx_exp.data);
                     check("stop_bit", tx, 1);
`ifdef UART_TX_PARITY_EN
                     check("parity_bit", rx_par, rx_exp.par);
`endif
                  end
                  rx_state = 0;
               end
         endcase
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      int   runs[$];
      logic last;
      int   run;
      int   bt_cnt;
      int   ticks;

      vecs[0] = '{8'h00, 8,  1'b0};
      vecs[1] = '{8'hFF, 9,  1'b0};
      vecs[2] = '{8'h80, 10, 1'b1};
      vecs[3] = '{8'h01, 7,  1'b1};
      vecs[4] = '{8'hA5, 16, 1'b0};
      vecs[5] = '{8'h3C, 5,  1'b0};
      vecs[6] = '{8'h07, 6,  1'b1};
      vecs[7] = '{8'h03, 11, 1'b0};

      rst_n     = 1'b0;
      baud_tick = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = '0;
      repeat (3) step();
      check("reset_tx", tx, 1);
      check("reset_ready", tx_ready, 1);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;

      // Idle line with no stimulus for 50 ticks.
      period = 8;
      for (int i = 0; i < 50 * 8; i++) begin
         if (baud_tick) begin
            check("idle_tx", tx, 1);
            check("idle_ready", tx_ready, 1);
            check("idle_busy", busy, 0);
         end
         step();
      end

      // Table of bytes at assorted tick rates.
      foreach (vecs[k]) begin
         period   = vecs[k].period;
         tick_cnt = 0;
         send(vecs[k].data, vecs[k].exp_par);
         wait_idle();
      end

      // 0x55 at 625 cycles per bit: every bit is a separate run on the line.
      period   = 625;
      tick_cnt = 0;
      send(8'h55, 1'b0);
      last   = tx;
      run    = 0;
      bt_cnt = 0;
      for (int i = 0; i < 20000; i++) begin
         if (!busy) break;
         if (baud_tick) bt_cnt++;
         step();
         if (tx == last) run++;
         else begin
            runs.push_back(run);
            run  = 1;
            last = tx;
         end
      end
      // Ticks seen while busy: the one launching the start bit plus one per
      // frame bit boundary.
      check("busy_ticks_55", bt_cnt, FRAME_TICKS + 1);
      check("ready_after_stop_55", tx_ready, 1);
      check("run_count_55", runs.size(), 10);
      for (int i = 1; i <= 8 && i < runs.size(); i++) check("bit_len_55", runs[i], 625);
      if (runs.size() > 9) check("last_run_55", runs[9], 625 * (1 + PAR_BITS));
      wait_idle();

      // tx_valid coincides with baud_tick: that tick must be ignored.
      auto_tick = 1'b0;
      baud_tick = 1'b1;
      tx_valid  = 1'b1;
      tx_data   = 8'hC3;
      exp_q.push_back('{8'hC3, 1'b0});
      step();
      tx_valid  = 1'b0;
      baud_tick = 1'b0;
      check("same_tick_accepted", tx_ready, 0);
      repeat (3) step();
      check("same_tick_ignored", tx, 1);
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      check("start_on_next_tick", tx, 0);
      period    = 6;
      tick_cnt  = 0;
      auto_tick = 1'b1;
      wait_idle();

      // Back-to-back with tx_valid held: second start on the next tick.
      period   = 12;
      tick_cnt = 0;
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      exp_q.push_back('{8'hA5, 1'b0});
      step();
      tx_data = 8'h3C;
      exp_q.push_back('{8'h3C, 1'b0});
      for (int i = 0; i < 20000 && !tx_ready; i++) step();
      step();
      tx_valid = 1'b0;
      check("b2b_second_accept", tx_ready, 0);
      ticks = 0;
      for (int i = 0; i < 1000; i++) begin
         if (tx == 1'b0) break;
         if (baud_tick) ticks++;
         step();
      end
      check("b2b_start_gap_ticks", ticks, 1);
      wait_idle();

      // Reset during data bit 3 of 0xFF, then a clean 0x01 frame.
      period   = 12;
      tick_cnt = 0;
      send(8'hFF, 1'b0);
      wait_ticks(5);
      repeat (3) step();
      check("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_reset_tx", tx, 1);
      check("mid_reset_ready", tx_ready, 1);
      check("mid_reset_busy", busy, 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (40) step();
      check("no_resume_tx", tx, 1);
      check("no_resume_busy", busy, 0);
      send(8'h01, 1'b1);
      wait_idle();

      repeat (5) step();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
